// File: rtl/xge_tx_arbiter_if.sv
// Packet bus between the traffic sources, the TX arbiter and the MAC pkt_tx port.
// slave  : the arbiter's view (consumes source words, drives the MAC side).
// master : the environment's view (sources and MAC FIFO status).
interface xge_tx_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 64
);
  logic [NUM_PORTS-1:0]        src_val;
  logic [NUM_PORTS-1:0]        src_sop;
  logic [NUM_PORTS-1:0]        src_eop;
  logic [3*NUM_PORTS-1:0]      src_mod;
  logic [DATA_W*NUM_PORTS-1:0] src_data;
  logic [NUM_PORTS-1:0]        src_ready;
  logic                        pkt_tx_full;
  logic                        pkt_tx_val;
  logic                        pkt_tx_sop;
  logic                        pkt_tx_eop;
  logic [2:0]                  pkt_tx_mod;
  logic [DATA_W-1:0]           pkt_tx_data;

  modport slave (
    input  src_val, src_sop, src_eop, src_mod, src_data, pkt_tx_full,
    output src_ready, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
  );

  modport master (
    output src_val, src_sop, src_eop, src_mod, src_data, pkt_tx_full,
    input  src_ready, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, pkt_tx_data
  );
endinterface

// File: rtl/xge_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the xge_mac pkt_tx port among
// NUM_PORTS sources (2..4), clk_156m25 domain, one registered output stage.
// Optional per-source packet counters: define XGE_TX_ARB_STATS_EN.
//
// state | meaning
// IDLE  | scan sources from rr_ptr for a sop candidate; discard one orphan word if none
// XFER  | forward granted source's words until its eop transfers
module xge_tx_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int DATA_W    = 64
) (
  input  logic            clk_156m25,
  input  logic            reset_156m25_n,
  xge_tx_arbiter_if.slave bus,
  output logic [1:0]      grant_idx,
  output logic            busy,
  output logic            err_drop
`ifdef XGE_TX_ARB_STATS_EN
  ,
  output logic [16*NUM_PORTS-1:0] pkt_cnt,
  input  logic                    stats_clr
`endif
);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t            r_state;
  logic [1:0]        r_rr_ptr;
  logic [1:0]        r_grant;
  logic              r_busy;
  logic              r_err;

  logic [2:0]        w_tgt;
  logic              w_cand_found;
  logic [1:0]        w_cand_idx;
  logic              w_orph_found;
  logic [1:0]        w_orph_idx;
  logic              w_sel_val;
  logic              w_sel_sop;
  logic              w_sel_eop;
  logic [2:0]        w_sel_mod;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_xfer;
  logic              w_drop;
  logic [1:0]        w_rr_next;

  // Round-robin scan for a sop candidate, plus lowest-index orphan (val without sop).
  always_comb begin
    w_tgt        = '0;
    w_cand_found = 1'b0;
    w_cand_idx   = '0;
    w_orph_found = 1'b0;
    w_orph_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_tgt = {1'b0, r_rr_ptr} + 3'(k);
      if (w_tgt >= 3'(NUM_PORTS)) w_tgt = w_tgt - 3'(NUM_PORTS);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!w_cand_found && (w_tgt == 3'(i)) && bus.src_val[i] && bus.src_sop[i]) begin
          w_cand_found = 1'b1;
          w_cand_idx   = 2'(i);
        end
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!w_orph_found && bus.src_val[i] && !bus.src_sop[i]) begin
        w_orph_found = 1'b1;
        w_orph_idx   = 2'(i);
      end
    end
  end

  // Select the granted source's word.
  always_comb begin
    w_sel_val  = 1'b0;
    w_sel_sop  = 1'b0;
    w_sel_eop  = 1'b0;
    w_sel_mod  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant == 2'(i)) begin
        w_sel_val  = bus.src_val[i];
        w_sel_sop  = bus.src_sop[i];
        w_sel_eop  = bus.src_eop[i];
        w_sel_mod  = bus.src_mod[3*i +: 3];
        w_sel_data = bus.src_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign w_xfer    = (r_state == XFER) && w_sel_val && !bus.pkt_tx_full;
  assign w_drop    = (r_state == IDLE) && !w_cand_found && w_orph_found;
  assign w_rr_next = (r_grant == 2'(NUM_PORTS - 1)) ? 2'd0 : r_grant + 2'd1;

  // Per-source ready: granted source in XFER, or the orphan being discarded in IDLE.
  always_comb begin
    bus.src_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_state == XFER)
        bus.src_ready[i] = (r_grant == 2'(i)) && !bus.pkt_tx_full;
      else
        bus.src_ready[i] = w_drop && (w_orph_idx == 2'(i));
    end
  end

  // Arbitration FSM with registered grant/busy/err_drop.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_drop;
      case (r_state)
        IDLE: begin
          if (w_cand_found) begin
            r_grant <= w_cand_idx;
            r_state <= XFER;
            r_busy  <= 1'b1;
          end
        end
        XFER: begin
          if (w_xfer && w_sel_eop) begin
            r_rr_ptr <= w_rr_next;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // MAC output register: val/sop/eop only for a word that transferred; mod/data hold.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      bus.pkt_tx_val  <= 1'b0;
      bus.pkt_tx_sop  <= 1'b0;
      bus.pkt_tx_eop  <= 1'b0;
      bus.pkt_tx_mod  <= '0;
      bus.pkt_tx_data <= '0;
    end else begin
      bus.pkt_tx_val <= w_xfer;
      if (w_xfer) begin
        bus.pkt_tx_sop  <= w_sel_sop;
        bus.pkt_tx_eop  <= w_sel_eop;
        bus.pkt_tx_mod  <= w_sel_mod;
        bus.pkt_tx_data <= w_sel_data;
      end else begin
        bus.pkt_tx_sop <= 1'b0;
        bus.pkt_tx_eop <= 1'b0;
      end
    end
  end

  assign grant_idx = r_grant;
  assign busy      = r_busy;
  assign err_drop  = r_err;

`ifdef XGE_TX_ARB_STATS_EN
  logic [15:0] r_cnt [NUM_PORTS];

  // Per-source packet counters; clear wins over a coincident increment.
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
    end else if (w_xfer && w_sel_eop) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (r_grant == 2'(i)) r_cnt[i] <= r_cnt[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_cnt[16*g +: 16] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_xge_tx_arbiter.sv
// Directed, table-driven bench for xge_tx_arbiter with three sources.
// Inputs change on the falling edge; src_ready is sampled 1 ns later, the
// registered outputs 1 ns after the following rising edge.
module tb_xge_tx_arbiter;
  localparam int NP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant_idx;
  logic       busy;
  logic       err_drop;
`ifdef XGE_TX_ARB_STATS_EN
  logic [16*NP-1:0] pkt_cnt;
  logic             stats_clr;
`endif

  int total = 0;
  int bad   = 0;

  xge_tx_arbiter_if #(.NUM_PORTS(NP), .DATA_W(64)) bus ();

  xge_tx_arbiter #(.NUM_PORTS(NP), .DATA_W(64)) dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .bus            (bus),
    .grant_idx      (grant_idx),
    .busy           (busy),
    .err_drop       (err_drop)
`ifdef XGE_TX_ARB_STATS_EN
    ,
    .pkt_cnt        (pkt_cnt),
    .stats_clr      (stats_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  val, sop, eop;
    logic [2:0]  mod;
    logic [15:0] tag;
    logic        full;
    logic [2:0]  e_rdy;
    logic        e_val, e_sop, e_eop;
    logic [2:0]  e_mod;
    logic [1:0]  e_src;
    logic [15:0] e_tag;
    logic [1:0]  e_gnt;
    logic        e_busy, e_err;
  } vec_t;

  vec_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] word(input int src, input logic [15:0] tag);
    return {32'(src), 16'h0, tag};
  endfunction

  task automatic drive(input logic [2:0] val, input logic [2:0] sop, input logic [2:0] eop,
                       input logic [2:0] mod, input logic [15:0] tag, input logic full);
    bus.src_val     = val;
    bus.src_sop     = sop;
    bus.src_eop     = eop;
    bus.src_mod     = {3{mod}};
    bus.pkt_tx_full = full;
    for (int i = 0; i < NP; i++) bus.src_data[64*i +: 64] = word(i, tag);
  endtask

  task automatic idle_inputs();
    drive(3'b000, 3'b000, 3'b000, 3'd0, 16'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
`ifdef XGE_TX_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    //        val     sop     eop     mod   tag       full  rdy     v     s     e     mod   src   tag       gnt   busy  err
    // source 0, 3-word packet, mod 5 on eop
    q.push_back('{3'b001, 3'b001, 3'b000, 3'd0, 16'h00A0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b001, 3'b001, 3'b000, 3'd0, 16'h00A0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h00A0, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b001, 3'b000, 3'b000, 3'd0, 16'h00A1, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 16'h00A1, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b001, 3'b000, 3'b001, 3'd5, 16'h00A2, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'd5, 2'd0, 16'h00A2, 2'd0, 1'b0, 1'b0});
    q.push_back('{3'b000, 3'b000, 3'b000, 3'd0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b0, 1'b0});
    // sources 0 and 1 compete; rr_ptr=1 so source 1 first, then alternating with one bubble
    q.push_back('{3'b011, 3'b011, 3'b000, 3'd0, 16'h00B0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1, 1'b1, 1'b0});
    q.push_back('{3'b011, 3'b011, 3'b000, 3'd0, 16'h00B0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1, 16'h00B0, 2'd1, 1'b1, 1'b0});
    q.push_back('{3'b011, 3'b001, 3'b010, 3'd3, 16'h00B1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 3'd3, 2'd1, 16'h00B1, 2'd1, 1'b0, 1'b0});
    q.push_back('{3'b011, 3'b011, 3'b000, 3'd0, 16'h00B2, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b011, 3'b011, 3'b000, 3'd0, 16'h00B2, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h00B2, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b011, 3'b010, 3'b001, 3'd0, 16'h00B3, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0, 16'h00B3, 2'd0, 1'b0, 1'b0});
    q.push_back('{3'b011, 3'b011, 3'b000, 3'd0, 16'h00B4, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1, 1'b1, 1'b0});
    // single-word packet from source 1
    q.push_back('{3'b010, 3'b010, 3'b010, 3'd7, 16'h00B4, 1'b0, 3'b010, 1'b1, 1'b1, 1'b1, 3'd7, 2'd1, 16'h00B4, 2'd1, 1'b0, 1'b0});
    q.push_back('{3'b000, 3'b000, 3'b000, 3'd0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1, 1'b0, 1'b0});
    // source 1, 5-word packet with pkt_tx_full high for 4 cycles
    q.push_back('{3'b010, 3'b010, 3'b000, 3'd0, 16'h00C0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1, 1'b1, 1'b0});
    q.push_back('{3'b010, 3'b010, 3'b000, 3'd0, 16'h00C0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 3'd0, 2'd1, 16'h00C0, 2'd1, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++)
      q.push_back('{3'b010, 3'b000, 3'b000, 3'd0, 16'h00C1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1, 1'b1, 1'b0});
    q.push_back('{3'b010, 3'b000, 3'b000, 3'd0, 16'h00C1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 16'h00C1, 2'd1, 1'b1, 1'b0});
    q.push_back('{3'b010, 3'b000, 3'b000, 3'd0, 16'h00C2, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 16'h00C2, 2'd1, 1'b1, 1'b0});
    q.push_back('{3'b010, 3'b000, 3'b000, 3'd0, 16'h00C3, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 3'd0, 2'd1, 16'h00C3, 2'd1, 1'b1, 1'b0});
    q.push_back('{3'b010, 3'b000, 3'b010, 3'd2, 16'h00C4, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 3'd2, 2'd1, 16'h00C4, 2'd1, 1'b0, 1'b0});
    // orphan word on source 2 while idle
    q.push_back('{3'b100, 3'b000, 3'b000, 3'd0, 16'h00D0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1, 1'b0, 1'b1});
    q.push_back('{3'b000, 3'b000, 3'b000, 3'd0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd1, 1'b0, 1'b0});
    // orphan suppressed by a sop candidate; non-granted source never sees ready in XFER
    q.push_back('{3'b101, 3'b001, 3'b000, 3'd0, 16'h00E0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b101, 3'b001, 3'b001, 3'd1, 16'h00E0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b1, 3'd1, 2'd0, 16'h00E0, 2'd0, 1'b0, 1'b0});
    q.push_back('{3'b100, 3'b000, 3'b000, 3'd0, 16'h0000, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b0, 1'b1});
    q.push_back('{3'b000, 3'b000, 3'b000, 3'd0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b0, 1'b0});
    // source 0 stalls mid-packet (grant held), then repeats sop on a non-first word
    q.push_back('{3'b001, 3'b001, 3'b000, 3'd0, 16'h00F0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b001, 3'b001, 3'b000, 3'd0, 16'h00F0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h00F0, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b000, 3'b000, 3'b000, 3'd0, 16'h00F1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b000, 3'b000, 3'b000, 3'd0, 16'h00F1, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b001, 3'b001, 3'b000, 3'd0, 16'h00F1, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 16'h00F1, 2'd0, 1'b1, 1'b0});
    q.push_back('{3'b001, 3'b000, 3'b001, 3'd4, 16'h00F2, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 3'd4, 2'd0, 16'h00F2, 2'd0, 1'b0, 1'b0});
    q.push_back('{3'b000, 3'b000, 3'b000, 3'd0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 16'h0000, 2'd0, 1'b0, 1'b0});

    // reset state
    #3;
    chk("rst.val", 64'(bus.pkt_tx_val), 64'd0);
    chk("rst.sop", 64'(bus.pkt_tx_sop), 64'd0);
    chk("rst.eop", 64'(bus.pkt_tx_eop), 64'd0);
    chk("rst.mod", 64'(bus.pkt_tx_mod), 64'd0);
    chk("rst.data", bus.pkt_tx_data, 64'd0);
    chk("rst.rdy", 64'(bus.src_ready), 64'd0);
    chk("rst.gnt", 64'(grant_idx), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.err", 64'(err_drop), 64'd0);
`ifdef XGE_TX_ARB_STATS_EN
    chk("rst.cnt", 64'(pkt_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.busy", 64'(busy), 64'd0);
    chk("idle.val", 64'(bus.pkt_tx_val), 64'd0);

    for (int i = 0; i < q.size(); i++) begin
      vec_t v;
      v = q[i];
      @(negedge clk);
      drive(v.val, v.sop, v.eop, v.mod, v.tag, v.full);
      #1;
      chk($sformatf("v%0d.rdy", i), 64'(bus.src_ready), 64'(v.e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d.val", i), 64'(bus.pkt_tx_val), 64'(v.e_val));
      chk($sformatf("v%0d.sop", i), 64'(bus.pkt_tx_sop), 64'(v.e_sop));
      chk($sformatf("v%0d.eop", i), 64'(bus.pkt_tx_eop), 64'(v.e_eop));
      if (v.e_val) begin
        chk($sformatf("v%0d.mod", i), 64'(bus.pkt_tx_mod), 64'(v.e_mod));
        chk($sformatf("v%0d.data", i), bus.pkt_tx_data, word(int'(v.e_src), v.e_tag));
      end
      chk($sformatf("v%0d.gnt", i), 64'(grant_idx), 64'(v.e_gnt));
      chk($sformatf("v%0d.busy", i), 64'(busy), 64'(v.e_busy));
      chk($sformatf("v%0d.err", i), 64'(err_drop), 64'(v.e_err));
    end

`ifdef XGE_TX_ARB_STATS_EN
    // eop transfers in the table: source 0 four, source 1 three
    chk("cnt0", 64'(pkt_cnt[15:0]), 64'd4);
    chk("cnt1", 64'(pkt_cnt[31:16]), 64'd3);
    chk("cnt2", 64'(pkt_cnt[47:32]), 64'd0);
    // clear coinciding with an increment leaves zero
    @(negedge clk);
    drive(3'b001, 3'b001, 3'b001, 3'd0, 16'h0C00, 1'b0);
    @(negedge clk);
    stats_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr.val", 64'(bus.pkt_tx_val), 64'd1);
    chk("clr.cnt", 64'(pkt_cnt), 64'd0);
    @(negedge clk);
    stats_clr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    chk("inc.cnt0", 64'(pkt_cnt[15:0]), 64'd1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
`endif

    // asynchronous reset in the middle of a source-1 packet (rr_ptr=1)
    @(negedge clk);
    drive(3'b010, 3'b010, 3'b000, 3'd0, 16'h0E00, 1'b0);
    @(posedge clk); #1;
    chk("mid.gnt", 64'(grant_idx), 64'd1);
    @(negedge clk);
    @(posedge clk); #1;
    chk("mid.val", 64'(bus.pkt_tx_val), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.val", 64'(bus.pkt_tx_val), 64'd0);
    chk("arst.sop", 64'(bus.pkt_tx_sop), 64'd0);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.gnt", 64'(grant_idx), 64'd0);
    chk("arst.rdy", 64'(bus.src_ready), 64'd0);
`ifdef XGE_TX_ARB_STATS_EN
    chk("arst.cnt", 64'(pkt_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b011, 3'b011, 3'b011, 3'd6, 16'h0E01, 1'b0);
    #1;
    chk("rel.rdy", 64'(bus.src_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel.gnt", 64'(grant_idx), 64'd0);
    chk("rel.busy", 64'(busy), 64'd1);
    @(negedge clk); #1;
    chk("rel.rdy2", 64'(bus.src_ready), 64'b001);
    @(posedge clk); #1;
    chk("rel.val", 64'(bus.pkt_tx_val), 64'd1);
    chk("rel.sop", 64'(bus.pkt_tx_sop), 64'd1);
    chk("rel.eop", 64'(bus.pkt_tx_eop), 64'd1);
    chk("rel.mod", 64'(bus.pkt_tx_mod), 64'd6);
    chk("rel.data", bus.pkt_tx_data, word(0, 16'h0E01));
    chk("rel.busy2", 64'(busy), 64'd0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/xge_tx_arbiter.md
Name: xge_tx_arbiter

Overview:
- Shares the MAC transmit packet interface (pkt_tx_*) among NUM_PORTS packet sources.
- Arbitrates round-robin at packet granularity and forwards the granted source's words to the MAC with one registered stage.
- Honours pkt_tx_full back-pressure.
- Sits between the traffic sources and the xge_mac pkt_tx port, in the clk_156m25 domain.

Parameters:
- NUM_PORTS, 2, number of requesters (2..4).
- DATA_W, 64, packet data width; fixed to match pkt_tx_data.

Ports:
- clk_156m25  in  1  core clock.
- reset_156m25_n  in  1  asynchronous active-low reset.
- src_val  in  NUM_PORTS  per-source word valid.
- src_sop  in  NUM_PORTS  per-source start of packet.
- src_eop  in  NUM_PORTS  per-source end of packet.
- src_mod  in  3*NUM_PORTS  per-source valid-byte count on eop (0 = 8 bytes), source i at bits [3i+2:3i].
- src_data  in  64*NUM_PORTS  per-source data, source i at bits [64i+63:64i].
- src_ready  out  NUM_PORTS  per-source word accepted this cycle.
- pkt_tx_full  in  1  MAC TX FIFO full.
- pkt_tx_val  out  1  word valid to MAC.
- pkt_tx_sop  out  1  start of packet to MAC.
- pkt_tx_eop  out  1  end of packet to MAC.
- pkt_tx_mod  out  3  byte modulus to MAC.
- pkt_tx_data  out  64  data to MAC.
- grant_idx  out  2  index of the currently granted source.
- busy  out  1  a packet is in progress.
- err_drop  out  1  one-cycle pulse: a word was discarded.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-packet:
  - state=IDLE, rr_ptr=0, grant_idx=0.
  - All pkt_tx_* outputs 0, src_ready=0, busy=0, err_drop=0.
  - No partial packet is resumed after reset.
- Transfer: a source word transfers in a cycle where src_val[i] && src_ready[i].
- src_ready[i] = (state==XFER) && (grant_idx==i) && !pkt_tx_full. Combinational from registered state and pkt_tx_full.
- Output stage, one cycle latency:
  - The cycle after a transfer: pkt_tx_val=1, and sop/eop/mod/data equal the transferred word.
  - Otherwise pkt_tx_val=0, and sop/eop are forced to 0.
  - data/mod hold their last value.
- State machine:
  - IDLE: scan sources starting at rr_ptr, wrapping modulo NUM_PORTS. The first i with src_val[i]&&src_sop[i] is latched into grant_idx; go to XFER next cycle. busy=0 in IDLE.
  - IDLE, no candidate: stay in IDLE.
  - XFER: busy=1.
    - On transfer of a word with eop=1: rr_ptr=grant_idx+1 (wraps), state goes to IDLE.
    - Each packet costs exactly one IDLE arbitration cycle, so the maximum rate is a burst followed by one bubble.
- Single-word packet (sop=eop=1): one XFER cycle, then IDLE.
- pkt_tx_full high: src_ready falls in the same cycle, and no new words transfer. At most one word already in the output register is presented to the MAC after full asserts; the MAC FIFO slack absorbs it. The state is held.
- Granted source deasserts src_val mid-packet: no transfer, pkt_tx_val=0 next cycle, grant held indefinitely. There is no timeout.
- Protocol errors:
  - Granted source presents sop=1 on a non-first word: the word is forwarded unchanged, the grant is kept, and err_drop is not asserted. The MAC handles it.
  - In IDLE, a non-granted candidate-scan source with val=1, sop=0 (orphan word): it is not eligible. In the IDLE cycle, src_ready for the lowest-index such source is pulsed to discard one word, and err_drop pulses the following cycle. This happens only if no valid sop candidate exists that cycle.
- Simultaneous sop requests: resolved by the rr_ptr scan order only.
- Sources other than grant_idx never see src_ready while in XFER.

Optional Feature:
- Macro: XGE_TX_ARB_STATS_EN.
- Defined:
  - Adds output pkt_cnt (16*NUM_PORTS): per-source packet counter, incremented on each transferred eop word of that source.
  - Wraps at 0xFFFF to 0; reset to 0.
  - Adds input stats_clr (1), a synchronous clear of all counters. If stats_clr and an increment coincide, the counter is 0.
- Undefined: no counters, no extra ports, and identical behaviour otherwise.

Test Plan:
- Reset then idle -> all outputs 0, busy=0. Assert reset_156m25_n low mid-packet -> pkt_tx_val drops immediately, and the next grant goes to source 0 after release.
- Source 0 sends a 3-word packet, eop mod=5 -> MAC sees sop, word, word(eop, mod=5) one cycle after each transfer. grant_idx=0. rr_ptr=1 after.
- Sources 0 and 1 both hold sop continuously, 2-word packets -> grants alternate 0,1,0,1. Exactly one pkt_tx_val=0 bubble between packets.
- pkt_tx_full high for 4 cycles during source 1's 5-word packet -> src_ready[1]=0 those cycles, no lost or duplicated words, and the 5 words arrive in order.
- Source 2 presents val=1, sop=0 while IDLE with no other requests -> one word discarded, err_drop=1 for one cycle, no pkt_tx_val.
- With XGE_TX_ARB_STATS_EN: 3 packets from source 0 and 1 from source 1 -> pkt_cnt[0]=3, pkt_cnt[1]=1. Preload 0xFFFF and send one more -> 0x0000.
